tank_ctrl: RTL and testbench

Per-tank movement and life controller that sits directly upstream of the tank display stage. It turns debounced direction buttons and hit events into the registered grid position, facing direction and alive flag consumed by the display stage. It is paced by an internal move-tick divider and tracks lives, respawn and game-over. One instance is used per tank.

---
 rtl/tank_pkg.sv | 35 +++
 rtl/tank_tick_gen.sv | 28 ++
 rtl/tank_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tank_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared encodings, grid limits and pixel mapping for tank_ctrl
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    DEAD  = 2'd1,
    OVER  = 2'd2
  } state_e;

  // Last legal cell on each axis and the default spawn cell.
  localparam int GRID_X_MAX  = 27;
  localparam int GRID_Y_MAX  = 19;
  localparam int SPAWN_X_DEF = 13;
  localparam int SPAWN_Y_DEF = 19;

  // Cell (x,y) is drawn centred at pixel (CELL_PX*x + ORIGIN_PX, CELL_PX*y + ORIGIN_PX).
  localparam int CELL_PX   = 20;
  localparam int ORIGIN_PX = 80;

  // Highest set button wins: up > down > left > right.
  function automatic dir_e btn_dir(input logic [3:0] btn);
    if (btn[3])      return DIR_UP;
    else if (btn[2]) return DIR_DOWN;
    else if (btn[1]) return DIR_LEFT;
    else             return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/tank_tick_gen.sv
// rtl/tank_tick_gen.sv - move-tick divider, one-cycle tick every DIV enabled cycles
module tick_gen #(
  parameter int DIV = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q;
  logic          at_top;

  assign at_top = (count_q == CW'(DIV - 1));
  assign tick   = en & at_top;

  // Count 0..DIV-1 and wrap; hold the count while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= at_top ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/tank_ctrl.sv
// rtl/tank_ctrl.sv - per-tank movement, lives and respawn controller; TANK_WRAP_EN makes edge moves wrap
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int MOVE_DIV      = 5000000,
  parameter int RESPAWN_TICKS = 8,
  parameter int LIVES         = 3,
  parameter int SPAWN_X       = SPAWN_X_DEF,
  parameter int SPAWN_Y       = SPAWN_Y_DEF,
  parameter int X_MAX         = GRID_X_MAX,
  parameter int Y_MAX         = GRID_Y_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] btn,
  input  logic       hit,
  output logic [4:0] x_rel_pos,
  output logic [4:0] y_rel_pos,
  output logic [1:0] tank_dir,
  output logic       tank_state,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       step
);

  localparam int RW = $clog2(RESPAWN_TICKS + 1);

`ifdef TANK_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  localparam logic [4:0] X_LIM   = 5'(X_MAX);
  localparam logic [4:0] Y_LIM   = 5'(Y_MAX);
  localparam logic [4:0] X_SPAWN = 5'(SPAWN_X);
  localparam logic [4:0] Y_SPAWN = 5'(SPAWN_Y);

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [4:0]    x_q, x_d, y_q, y_d;
  logic [1:0]    lives_q, lives_d;
  logic [RW-1:0] resp_q, resp_d, resp_inc;
  logic          alive_q, alive_d;
  logic          over_q, over_d;
  logic          step_q, step_d;

  logic          tick;
  dir_e          req;
  logic          req_valid;
  logic [4:0]    x_mv, y_mv;
  logic          at_edge;
  logic          move_ok;
  logic          resp_done;

  tick_gen #(
    .DIV (MOVE_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .tick (tick)
  );

  assign req       = btn_dir(btn);
  assign req_valid = |btn;
  assign resp_inc  = resp_q + 1'b1;
  assign resp_done = (resp_inc == RW'(RESPAWN_TICKS));
  assign move_ok   = at_edge ? WRAP_ON : 1'b1;

  // Target cell for a one-cell move in the requested direction, wrapped at the edges.
  always_comb begin
    x_mv    = x_q;
    y_mv    = y_q;
    at_edge = 1'b0;
    case (req)
      DIR_UP: begin
        at_edge = (y_q == 5'd0);
        y_mv    = at_edge ? Y_LIM : y_q - 5'd1;
      end
      DIR_DOWN: begin
        at_edge = (y_q == Y_LIM);
        y_mv    = at_edge ? 5'd0 : y_q + 5'd1;
      end
      DIR_LEFT: begin
        at_edge = (x_q == 5'd0);
        x_mv    = at_edge ? X_LIM : x_q - 5'd1;
      end
      default: begin
        at_edge = (x_q == X_LIM);
        x_mv    = at_edge ? 5'd0 : x_q + 5'd1;
      end
    endcase
  end

  // State and output registers; rst beats enable, enable=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALIVE;
      dir_q   <= DIR_UP;
      x_q     <= X_SPAWN;
      y_q     <= Y_SPAWN;
      lives_q <= 2'(LIVES);
      resp_q  <= '0;
      alive_q <= 1'b1;
      over_q  <= 1'b0;
      step_q  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      resp_q  <= resp_d;
      alive_q <= alive_d;
      over_q  <= over_d;
      step_q  <= step_d;
    end
  end

  // Next FSM state: hits leave ALIVE, the final respawn tick leaves DEAD, OVER absorbs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALIVE:   if (hit) state_d = (lives_q == 2'd1) ? OVER : DEAD;
      DEAD:    if (tick && resp_done) state_d = ALIVE;
      OVER:    state_d = OVER;
      default: state_d = ALIVE;
    endcase
  end

  // Next values of position, direction, lives, respawn count and the visible flags.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    lives_d = lives_q;
    resp_d  = resp_q;
    alive_d = alive_q;
    over_d  = over_q;
    step_d  = 1'b0;
    case (state_q)
      ALIVE: begin
        if (hit) begin
          lives_d = lives_q - 2'd1;
          alive_d = 1'b0;
          resp_d  = '0;
          if (lives_q == 2'd1) over_d = 1'b1;
        end else if (tick && req_valid) begin
          if (req != dir_q) begin
            dir_d = req;
          end else if (move_ok) begin
            x_d    = x_mv;
            y_d    = y_mv;
            step_d = 1'b1;
          end
        end
      end
      DEAD: begin
        if (tick) begin
          resp_d = resp_inc;
          if (resp_done) begin
            x_d     = X_SPAWN;
            y_d     = Y_SPAWN;
            dir_d   = DIR_UP;
            alive_d = 1'b1;
          end
        end
      end
      default: begin
        alive_d = 1'b0;
        over_d  = 1'b1;
      end
    endcase
  end

  assign x_rel_pos  = x_q;
  assign y_rel_pos  = y_q;
  assign tank_dir   = dir_q;
  assign tank_state = alive_q;
  assign lives      = lives_q;
  assign game_over  = over_q;
  assign step       = step_q;

endmodule

// File: tb/tb_tank_ctrl.sv
// tb/tb_tank_ctrl.sv - self-checking bench for tank_ctrl against a behavioural model
module tb_tank_ctrl;

  localparam int MD = 4;
  localparam int RT = 2;
  localparam int XM = 27;
  localparam int YM = 19;
`ifdef TANK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       hit = 1'b0;
  logic [4:0] x_rel_pos, y_rel_pos;
  logic [1:0] tank_dir, lives;
  logic       tank_state, game_over, step;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Behavioural model: mode 0 alive, 1 dead, 2 game over.
  int m_div, m_x, m_y, m_dir, m_mode, m_resp, m_lives, m_go, m_step;

  tank_ctrl #(
    .MOVE_DIV      (MD),
    .RESPAWN_TICKS (RT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .btn        (btn),
    .hit        (hit),
    .x_rel_pos  (x_rel_pos),
    .y_rel_pos  (y_rel_pos),
    .tank_dir   (tank_dir),
    .tank_state (tank_state),
    .lives      (lives),
    .game_over  (game_over),
    .step       (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic en, input logic [3:0] b, input logic h, input logic r);
    bit tick;
    int rq, nx, ny;
    if (r) begin
      m_div = 0; m_x = 13; m_y = 19; m_dir = 0; m_mode = 0;
      m_resp = 0; m_lives = 3; m_go = 0; m_step = 0;
      return;
    end
    if (!en) return;
    tick  = (m_div == MD - 1);
    m_div = (m_div + 1) % MD;
    m_step = 0;
    if (m_mode == 0) begin
      if (h) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) begin
          m_mode = 2;
          m_go = 1;
        end else begin
          m_mode = 1;
          m_resp = 0;
        end
      end else if (tick && b != 4'b0000) begin
        rq = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
        if (rq != m_dir) begin
          m_dir = rq;
        end else begin
          nx = m_x + ((rq == 3) ? 1 : (rq == 2) ? -1 : 0);
          ny = m_y + ((rq == 1) ? 1 : (rq == 0) ? -1 : 0);
          if (nx >= 0 && nx <= XM && ny >= 0 && ny <= YM) begin
            m_x = nx; m_y = ny; m_step = 1;
          end else if (WRAP) begin
            m_x = (nx + XM + 1) % (XM + 1);
            m_y = (ny + YM + 1) % (YM + 1);
            m_step = 1;
          end
        end
      end
    end else if (m_mode == 1) begin
      if (tick) begin
        m_resp++;
        if (m_resp == RT) begin
          m_mode = 0; m_x = 13; m_y = 19; m_dir = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("x", x_rel_pos, m_x);
    chk("y", y_rel_pos, m_y);
    chk("dir", tank_dir, m_dir);
    chk("tank_state", tank_state, (m_mode == 0) ? 1 : 0);
    chk("lives", lives, m_lives);
    chk("game_over", game_over, m_go);
    chk("step", step, m_step);
  endtask

  task automatic cyc(input logic en, input logic [3:0] b, input logic h, input logic r);
    enable = en; btn = b; hit = h; rst = r;
    @(posedge clk);
    model_step(en, b, h, r);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n, input logic [3:0] b);
    for (int i = 0; i < n * MD; i++) cyc(1'b1, b, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] held;
    logic       r, e, h;

    // Reset state
    cyc(1'b0, 4'b0000, 1'b0, 1'b1);
    cyc(1'b1, 4'b0000, 1'b0, 1'b1);
    chk("rst_x", x_rel_pos, 13);
    chk("rst_y", y_rel_pos, 19);
    chk("rst_lives", lives, 3);
    chk("rst_state", tank_state, 1);

    // Hold up: two steps
    ticks(1, 4'b1000);
    chk("up1_y", y_rel_pos, 18);
    chk("up1_step", step, 1);
    ticks(1, 4'b1000);
    chk("up2_y", y_rel_pos, 17);

    // Right: turn first, then step
    ticks(1, 4'b0001);
    chk("turn_dir", tank_dir, 3);
    chk("turn_x", x_rel_pos, 13);
    chk("turn_step", step, 0);
    ticks(1, 4'b0001);
    chk("right_x", x_rel_pos, 14);

    // Right edge
    ticks(13, 4'b0001);
    chk("edge_reach_x", x_rel_pos, 27);
    ticks(1, 4'b0001);
`ifdef TANK_WRAP_EN
    chk("edge_x", x_rel_pos, 0);
    chk("edge_step", step, 1);
`else
    chk("edge_x", x_rel_pos, 27);
    chk("edge_step", step, 0);
`endif

    // Hit, dead with buttons held, respawn after two ticks
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    chk("hit_state", tank_state, 0);
    chk("hit_lives", lives, 2);
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'b1000, 1'b0, 1'b0);
    chk("resp_x", x_rel_pos, 13);
    chk("resp_y", y_rel_pos, 19);
    chk("resp_dir", tank_dir, 0);
    chk("resp_state", tank_state, 1);

    // Second and third hits lead to game over
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    chk("over_lives", lives, 0);
    chk("over_go", game_over, 1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'b1000, 1'b1, 1'b0);
    chk("over_hold_go", game_over, 1);
    chk("over_hold_state", tank_state, 0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b1);
    chk("rst_after_over_lives", lives, 3);
    chk("rst_after_over_go", game_over, 0);

    // Hit in the tick cycle beats the move
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b1000, 1'b1, 1'b0);
    chk("hit_tick_y", y_rel_pos, 19);
    chk("hit_tick_step", step, 0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b1);

    // Enable low freezes outputs and divider
    cyc(1'b1, 4'b1000, 1'b0, 1'b0);
    cyc(1'b1, 4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'b1000, 1'b1, 1'b0);
    chk("freeze_y", y_rel_pos, 19);
    chk("freeze_state", tank_state, 1);
    cyc(1'b1, 4'b1000, 1'b0, 1'b0);
    chk("resume_pre_y", y_rel_pos, 19);
    cyc(1'b1, 4'b1000, 1'b0, 1'b0);
    chk("resume_y", y_rel_pos, 18);
    chk("resume_step", step, 1);

    // Randomized traffic against the model
    held = 4'b0000;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0) held = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      h = ($urandom_range(0, 29) == 0);
      cyc(e, held, h, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
